// File: rtl/pong_game_ctrl_if.sv
// Pong controller bus: frame tick and buttons in,
// registered paddle/ball/score/state values out.
interface pong_game_ctrl_if;
   logic       frame_tick;
   logic       up1;
   logic       down1;
   logic       up2;
   logic       down2;
   logic       start;
   logic [9:0] paddle1_y;
   logic [9:0] paddle2_y;
   logic [9:0] ball_x;
   logic [9:0] ball_y;
   logic [3:0] score1;
   logic [3:0] score2;
   logic [2:0] game_state;
   logic       game_over;

   modport master (
      input  frame_tick, up1, down1, up2, down2, start,
      output paddle1_y, paddle2_y, ball_x, ball_y,
      output score1, score2, game_state, game_over
   );

   modport slave (
      output frame_tick, up1, down1, up2, down2, start,
      input  paddle1_y, paddle2_y, ball_x, ball_y,
      input  score1, score2, game_state, game_over
   );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong frame-rate sequencer: paddles, ball, bounces, scoring
// and the serve / play / game-over state machine.
module pong_game_ctrl #(
   parameter int H_RES        = 640,
   parameter int V_RES        = 480,
   parameter int PADDLE_H     = 64,
   parameter int PADDLE_W     = 8,
   parameter int PADDLE_X1    = 16,
   parameter int PADDLE_X2    = 616,
   parameter int BALL_SIZE    = 8,
   parameter int PADDLE_STEP  = 4,
   parameter int BALL_STEP    = 2,
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60
) (
   input logic              iVGA_CLK,
   input logic              iRST_n,
   pong_game_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SERVE = 3'd1,
      PLAY  = 3'd2,
      POINT = 3'd3,
      OVER  = 3'd4
   } state_t;

   localparam int CW = $clog2(SERVE_FRAMES);
   localparam logic [9:0] P_MAX  = 10'(V_RES - PADDLE_H);
   localparam logic [9:0] P_H    = 10'(PADDLE_H);
   localparam logic [9:0] P_STEP = 10'(PADDLE_STEP);
   localparam logic [9:0] B_STEP = 10'(BALL_STEP);
   localparam logic [9:0] B_SIZE = 10'(BALL_SIZE);
   localparam logic [9:0] FACE1  = 10'(PADDLE_X1 + PADDLE_W);
   localparam logic [9:0] FACE2  = 10'(PADDLE_X2);
   localparam logic [9:0] X_MISS = 10'(H_RES - BALL_STEP);
   localparam logic [9:0] Y_WALL = 10'(V_RES - BALL_STEP);
   localparam logic [9:0] Y_BOT  = 10'(V_RES - BALL_SIZE);
   localparam logic [9:0] X_C    = 10'((H_RES - BALL_SIZE) / 2);
   localparam logic [9:0] Y_C    = 10'((V_RES - BALL_SIZE) / 2);
   localparam logic [9:0] P_C    = 10'((V_RES - PADDLE_H) / 2);
   localparam logic [3:0] WIN    = 4'(WIN_SCORE);
   localparam logic [CW-1:0] CNT_LAST = CW'(SERVE_FRAMES - 1);

   logic [4:0]    btn_s1, btn_s2;
   logic          start_s3, start_pulse;
   logic          u1, d1, u2, d2;
   state_t        state_q, state_d;
   logic [9:0]    p1_q, p1_d, p2_q, p2_d;
   logic [9:0]    bx_q, bx_d, by_q, by_d;
   logic [9:0]    p1_mv, p2_mv;
   logic          dxr_q, dxr_d, dyd_q, dyd_d;
   logic          pw1_q, pw1_d, go_q;
   logic [3:0]    s1_q, s1_d, s2_q, s2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit1, hit2, miss1, miss2;

   function automatic logic [9:0] paddle_move(
      input logic [9:0] y,
      input logic       up,
      input logic       dn
   );
      logic [9:0] r;
      r = y;
      if (up && !dn)
         r = (y >= P_STEP) ? y - P_STEP : '0;
      else if (dn && !up)
         r = (y + P_STEP <= P_MAX) ? y + P_STEP : P_MAX;
      return r;
   endfunction

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         btn_s1   <= '0;
         btn_s2   <= '0;
         start_s3 <= 1'b0;
      end else begin
         btn_s1   <= {bus.start, bus.down2, bus.up2,
                      bus.down1, bus.up1};
         btn_s2   <= btn_s1;
         start_s3 <= btn_s2[4];
      end
   end

   assign {d2, u2, d1, u1} = btn_s2[3:0];
   assign start_pulse = btn_s2[4] & ~start_s3;
   assign p1_mv = paddle_move(p1_q, u1, d1);
   assign p2_mv = paddle_move(p2_q, u2, d2);

   // Contact tests use the pre-tick ball and paddle positions.
   assign hit1 = !dxr_q && bx_q >= FACE1
              && bx_q - B_STEP < FACE1
              && by_q + B_SIZE > p1_q
              && by_q < p1_q + P_H;
   assign hit2 = dxr_q && bx_q + B_SIZE <= FACE2
              && bx_q + B_SIZE + B_STEP > FACE2
              && by_q + B_SIZE > p2_q
              && by_q < p2_q + P_H;
   assign miss1 = dxr_q && bx_q + B_SIZE > X_MISS;
   assign miss2 = !dxr_q && bx_q < B_STEP;

   always_comb begin
      state_d = state_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      bx_d    = bx_q;
      by_d    = by_q;
      dxr_d   = dxr_q;
      dyd_d   = dyd_q;
      pw1_d   = pw1_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            bx_d = X_C;
            by_d = Y_C;
            s1_d = '0;
            s2_d = '0;
            if (start_pulse) begin
               state_d = SERVE;
               cnt_d   = '0;
            end
         end
         SERVE: begin
            bx_d = X_C;
            by_d = Y_C;
            if (bus.frame_tick) begin
               p1_d = p1_mv;
               p2_d = p2_mv;
               if (cnt_q == CNT_LAST) begin
                  state_d = PLAY;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         PLAY: begin
            if (bus.frame_tick) begin
               p1_d = p1_mv;
               p2_d = p2_mv;
               if (!dyd_q && by_q <= B_STEP) begin
                  by_d  = '0;
                  dyd_d = 1'b1;
               end else if (dyd_q && by_q + B_SIZE >= Y_WALL) begin
                  by_d  = Y_BOT;
                  dyd_d = 1'b0;
               end else if (dyd_q) begin
                  by_d = by_q + B_STEP;
               end else begin
                  by_d = by_q - B_STEP;
               end
               if (hit1) begin
                  bx_d  = FACE1;
                  dxr_d = 1'b1;
               end else if (hit2) begin
                  bx_d  = FACE2 - B_SIZE;
                  dxr_d = 1'b0;
               end else if (miss1 || miss2) begin
                  state_d = POINT;
                  pw1_d   = miss1;
               end else if (dxr_q) begin
                  bx_d = bx_q + B_STEP;
               end else begin
                  bx_d = bx_q - B_STEP;
               end
            end
         end
         POINT: begin
            bx_d  = X_C;
            by_d  = Y_C;
            cnt_d = '0;
            // Next serve heads toward whoever conceded.
            dxr_d = pw1_q;
            if (pw1_q) begin
               s1_d    = s1_q + 4'd1;
               state_d = (s1_d == WIN) ? OVER : SERVE;
            end else begin
               s2_d    = s2_q + 4'd1;
               state_d = (s2_d == WIN) ? OVER : SERVE;
            end
         end
         OVER: begin
            if (start_pulse) begin
               s1_d    = '0;
               s2_d    = '0;
               bx_d    = X_C;
               by_d    = Y_C;
               p1_d    = P_C;
               p2_d    = P_C;
               cnt_d   = '0;
               state_d = SERVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q <= IDLE;
         p1_q    <= P_C;
         p2_q    <= P_C;
         bx_q    <= X_C;
         by_q    <= Y_C;
         dxr_q   <= 1'b1;
         dyd_q   <= 1'b1;
         pw1_q   <= 1'b0;
         s1_q    <= '0;
         s2_q    <= '0;
         cnt_q   <= '0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         dxr_q   <= dxr_d;
         dyd_q   <= dyd_d;
         pw1_q   <= pw1_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         cnt_q   <= cnt_d;
         go_q    <= (state_d == OVER);
      end
   end

   assign bus.paddle1_y  = p1_q;
   assign bus.paddle2_y  = p2_q;
   assign bus.ball_x     = bx_q;
   assign bus.ball_y     = by_q;
   assign bus.score1     = s1_q;
   assign bus.score2     = s2_q;
   assign bus.game_state = state_q;
   assign bus.game_over  = go_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomised bench for pong_game_ctrl, checked against a
// frame-level model of the game rules.
module tb_pong_game_ctrl;
   localparam int S_IDLE  = 0;
   localparam int S_SERVE = 1;
   localparam int S_PLAY  = 2;
   localparam int S_POINT = 3;
   localparam int S_OVER  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int errors = 0;
   int checks = 0;

   int m_st, m_p1, m_p2, m_bx, m_by;
   int m_s1, m_s2, m_cnt, m_pw, m_hit;
   bit m_dxr, m_dyd;

   logic [51:0] dut_vec;
   logic [30:0] dut_pt;

   always #5 clk = ~clk;

   pong_game_ctrl_if bus ();

   pong_game_ctrl dut (
      .iVGA_CLK (clk),
      .iRST_n   (rst_n),
      .bus      (bus)
   );

   assign dut_vec = {bus.paddle1_y, bus.paddle2_y,
                     bus.ball_x, bus.ball_y,
                     bus.score1, bus.score2,
                     bus.game_state, bus.game_over};
   assign dut_pt = {bus.paddle1_y, bus.paddle2_y,
                    bus.score1, bus.score2, bus.game_state};

   function automatic int clampi(int v, int lo, int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic logic [51:0] model_vec();
      return {10'(m_p1), 10'(m_p2), 10'(m_bx), 10'(m_by),
              4'(m_s1), 4'(m_s2), 3'(m_st), (m_st == S_OVER)};
   endfunction

   function automatic logic [30:0] model_pt();
      return {10'(m_p1), 10'(m_p2),
              4'(m_s1), 4'(m_s2), 3'(m_st)};
   endfunction

   function automatic void model_reset();
      m_st  = S_IDLE;
      m_p1  = 208;
      m_p2  = 208;
      m_bx  = 316;
      m_by  = 236;
      m_dxr = 1'b1;
      m_dyd = 1'b1;
      m_s1  = 0;
      m_s2  = 0;
      m_cnt = 0;
      m_pw  = 0;
      m_hit = 0;
   endfunction

   function automatic void model_start();
      if (m_st == S_IDLE) begin
         m_st  = S_SERVE;
         m_cnt = 0;
      end else if (m_st == S_OVER) begin
         m_s1  = 0;
         m_s2  = 0;
         m_bx  = 316;
         m_by  = 236;
         m_p1  = 208;
         m_p2  = 208;
         m_cnt = 0;
         m_st  = S_SERVE;
      end
   endfunction

   function automatic void model_tick(bit u1, bit d1,
                                      bit u2, bit d2);
      int ox = m_bx;
      int oy = m_by;
      int op1 = m_p1;
      int op2 = m_p2;
      bit h1, h2;
      m_hit = 0;
      if (m_st != S_SERVE && m_st != S_PLAY) return;
      m_p1 = clampi(op1 + 4 * (int'(d1) - int'(u1)), 0, 416);
      m_p2 = clampi(op2 + 4 * (int'(d2) - int'(u2)), 0, 416);
      if (m_st == S_SERVE) begin
         m_cnt++;
         if (m_cnt == 60) begin
            m_st  = S_PLAY;
            m_cnt = 0;
         end
         return;
      end
      if (!m_dyd && oy <= 2) begin
         m_by  = 0;
         m_dyd = 1'b1;
      end else if (m_dyd && oy + 8 >= 478) begin
         m_by  = 472;
         m_dyd = 1'b0;
      end else begin
         m_by = oy + (m_dyd ? 2 : -2);
      end
      h1 = !m_dxr && ox >= 24 && ox - 2 < 24
           && oy + 8 > op1 && oy < op1 + 64;
      h2 = m_dxr && ox + 8 <= 616 && ox + 10 > 616
           && oy + 8 > op2 && oy < op2 + 64;
      if (h1) begin
         m_bx  = 24;
         m_dxr = 1'b1;
         m_hit = 1;
      end else if (h2) begin
         m_bx  = 608;
         m_dxr = 1'b0;
         m_hit = 2;
      end else if (!m_dxr && ox < 2) begin
         m_st = S_POINT;
         m_pw = 2;
      end else if (m_dxr && ox + 8 > 638) begin
         m_st = S_POINT;
         m_pw = 1;
      end else begin
         m_bx = ox + (m_dxr ? 2 : -2);
      end
   endfunction

   function automatic void model_point();
      if (m_pw == 1) begin
         m_s1++;
         m_dxr = 1'b1;
      end else begin
         m_s2++;
         m_dxr = 1'b0;
      end
      m_bx  = 316;
      m_by  = 236;
      m_cnt = 0;
      m_st  = (m_s1 == 7 || m_s2 == 7) ? S_OVER : S_SERVE;
   endfunction

   function automatic logic [1:0] track(int p);
      int pc = p + 32;
      int bc = m_by + 4;
      if (pc > bc + 2) return 2'b10;
      if (pc < bc - 2) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [1:0] avoid();
      return (m_by + 4 < 240) ? 2'b01 : 2'b10;
   endfunction

   task automatic frame(input bit u1, d1, u2, d2);
      bus.up1   = u1;
      bus.down1 = d1;
      bus.up2   = u2;
      bus.down2 = d2;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      model_tick(u1, d1, u2, d2);
   endtask

   task automatic point_clock();
      @(negedge clk);
      model_point();
   endtask

   task automatic press_start();
      bus.start = 1'b1;
      repeat (4) @(negedge clk);
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      model_start();
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL reset_hold: got %h want %h",
                  dut_vec, model_vec());
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL reset_idle: got %h want %h",
                  dut_vec, model_vec());
      end
   endtask

   task automatic test_paddle_saturation();
      press_start();
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL serve_entry: got %h want %h",
                  dut_vec, model_vec());
      end
      for (int i = 0; i < 55; i++) begin
         frame(1, 0, 0, 0);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL sat_up %0d: got %h want %h",
                     i, dut_vec, model_vec());
         end
      end
      checks++;
      if (bus.paddle1_y !== 10'd0) begin
         errors++;
         $display("FAIL sat_top: got %0d want 0", bus.paddle1_y);
      end
      for (int i = 0; i < 3; i++) begin
         frame(1, 1, 0, 0);
         checks++;
         if (bus.paddle1_y !== 10'd0) begin
            errors++;
            $display("FAIL sat_both %0d: got %0d want 0",
                     i, bus.paddle1_y);
         end
      end
      for (int i = 0; i < 112; i++) begin
         frame(0, 1, 0, 0);
         if (m_st == S_POINT) begin
            checks++;
            if (dut_pt !== model_pt()) begin
               errors++;
               $display("FAIL sat_point: got %h want %h",
                        dut_pt, model_pt());
            end
            point_clock();
         end
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL sat_down %0d: got %h want %h",
                     i, dut_vec, model_vec());
         end
         if (i == 1) begin
            checks++;
            if (bus.game_state !== 3'd2) begin
               errors++;
               $display("FAIL serve_to_play: got %0d want 2",
                        bus.game_state);
            end
         end
      end
      checks++;
      if (bus.paddle1_y !== 10'd416) begin
         errors++;
         $display("FAIL sat_bottom: got %0d want 416",
                  bus.paddle1_y);
      end
   endtask

   task automatic test_random_play();
      logic [3:0] b;
      for (int i = 0; i < 400; i++) begin
         if (i % 100 == 50) press_start();
         b = 4'($urandom_range(0, 15));
         frame(b[0], b[1], b[2], b[3]);
         if (m_st == S_POINT) begin
            checks++;
            if (dut_pt !== model_pt()) begin
               errors++;
               $display("FAIL rand_point: got %h want %h",
                        dut_pt, model_pt());
            end
            point_clock();
         end
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL rand_play %0d: got %h want %h",
                     i, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_paddle_hit();
      logic [1:0] t1, t2;
      for (int i = 0; i < 700; i++) begin
         t1 = track(m_p1);
         t2 = track(m_p2);
         frame(t1[1], t1[0], t2[1], t2[0]);
         if (m_st == S_POINT) begin
            checks++;
            if (dut_pt !== model_pt()) begin
               errors++;
               $display("FAIL hit_point: got %h want %h",
                        dut_pt, model_pt());
            end
            point_clock();
         end
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL hit_play %0d: got %h want %h",
                     i, dut_vec, model_vec());
         end
         if (m_hit == 1) begin
            checks++;
            if (bus.ball_x !== 10'd24) begin
               errors++;
               $display("FAIL hit1_x: got %0d want 24",
                        bus.ball_x);
            end
         end else if (m_hit == 2) begin
            checks++;
            if (bus.ball_x !== 10'd608) begin
               errors++;
               $display("FAIL hit2_x: got %0d want 608",
                        bus.ball_x);
            end
         end
      end
   endtask

   task automatic test_miss_game_over();
      logic [1:0] t1, t2;
      logic [3:0] b;
      for (int i = 0; i < 6000 && m_st != S_OVER; i++) begin
         t1 = track(m_p1);
         t2 = avoid();
         frame(t1[1], t1[0], t2[1], t2[0]);
         if (m_st == S_POINT) begin
            checks++;
            if (dut_pt !== model_pt()) begin
               errors++;
               $display("FAIL miss_point: got %h want %h",
                        dut_pt, model_pt());
            end
            point_clock();
         end
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL miss_play %0d: got %h want %h",
                     i, dut_vec, model_vec());
         end
      end
      checks++;
      if (bus.game_over !== 1'b1 || bus.game_state !== 3'd4) begin
         errors++;
         $display("FAIL game_over: got %0d/%0d want 1/4",
                  bus.game_over, bus.game_state);
      end
      for (int i = 0; i < 10; i++) begin
         b = 4'($urandom_range(0, 15));
         frame(b[0], b[1], b[2], b[3]);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL over_frozen %0d: got %h want %h",
                     i, dut_vec, model_vec());
         end
      end
   endtask

   task automatic test_restart();
      logic [3:0] b;
      press_start();
      checks++;
      if (bus.game_state !== 3'd1 || bus.score1 !== 4'd0
          || bus.score2 !== 4'd0) begin
         errors++;
         $display("FAIL restart: got st=%0d s=%0d/%0d want 1 0/0",
                  bus.game_state, bus.score1, bus.score2);
      end
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL restart_vec: got %h want %h",
                  dut_vec, model_vec());
      end
      for (int i = 0; i < 60; i++) begin
         b = 4'($urandom_range(0, 15));
         frame(b[0], b[1], b[2], b[3]);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL restart_serve %0d: got %h want %h",
                     i, dut_vec, model_vec());
         end
      end
      checks++;
      if (bus.game_state !== 3'd2) begin
         errors++;
         $display("FAIL restart_play: got %0d want 2",
                  bus.game_state);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         frame(0, 0, 0, 0);
         if (m_st == S_POINT) point_clock();
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL async_reset: got %h want %h",
                  dut_vec, model_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (dut_vec !== model_vec()) begin
         errors++;
         $display("FAIL reset_release: got %h want %h",
                  dut_vec, model_vec());
      end
   endtask

   initial begin
      bus.frame_tick = 1'b0;
      bus.up1   = 1'b0;
      bus.down1 = 1'b0;
      bus.up2   = 1'b0;
      bus.down2 = 1'b0;
      bus.start = 1'b0;
      model_reset();
      test_reset();
      test_paddle_saturation();
      test_random_play();
      test_paddle_hit();
      test_miss_game_over();
      test_restart();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Frame-rate game sequencer for Pong, clocked by the VGA pixel clock between the button inputs (up1/down1/up2/down2 plus a start button) and vga_controller. Once per video frame it advances both paddles and the ball and resolves wall bounces, paddle hits and misses. It also keeps score and runs the serve / play / game-over state machine. vga_controller reads its registered position outputs to draw the frame.

## Interface
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height in pixels.
- PADDLE_H, 64: paddle height.
- PADDLE_W, 8: paddle width.
- PADDLE_X1, 16: left edge x of paddle 1.
- PADDLE_X2, 616: left edge x of paddle 2.
- BALL_SIZE, 8: ball square side.
- PADDLE_STEP, 4: paddle pixels per frame.
- BALL_STEP, 2: ball pixels per frame, per axis.
- WIN_SCORE, 7: points that end the game.
- SERVE_FRAMES, 60: frames the ball is held centred before launch.

Ports:
- iVGA_CLK  in  1  pixel clock; the only clock.
- iRST_n  in  1  reset; asynchronous assert, active-low.
- frame_tick  in  1  one-cycle pulse per frame at vblank start.
- up1, down1, up2, down2  in  1 each  buttons; asynchronous, active-high.
- start  in  1  start button; asynchronous, active-high.
- paddle1_y, paddle2_y  out  10  top y of each paddle.
- ball_x, ball_y  out  10  top-left corner of the ball.
- score1, score2  out  4  points for each player.
- game_state  out  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4.
- game_over  out  1  high in OVER.

## Operation
- **Input synchronisation:** every button goes through a 2-flop synchroniser. `start` acts on the rising edge of its synchronised value (start_pulse).
- **Reset values:**
  - paddle1_y = paddle2_y = (V_RES−PADDLE_H)/2 = 208.
  - ball = ((H_RES−BALL_SIZE)/2, (V_RES−BALL_SIZE)/2) = (316, 236).
  - dx = right, dy = down.
  - scores = 0, state = IDLE, game_over = 0.
- **Paddles:** move on frame_tick, in SERVE and PLAY only.
  - Up only: y −= PADDLE_STEP, saturating at 0.
  - Down only: y += PADDLE_STEP, saturating at V_RES−PADDLE_H.
  - Both or neither: hold.
- **IDLE:** ball centred, scores held at 0. start_pulse → SERVE.
- **SERVE:** ball held centred. A frame counter counts SERVE_FRAMES ticks, then → PLAY.
- **PLAY, on each frame_tick:** each check below uses pre-tick values, including pre-tick paddle positions.
  - Vertical wall:
    - Moving up with ball_y ≤ BALL_STEP: ball_y = 0, dy becomes down.
    - Moving down with ball_y+BALL_SIZE ≥ V_RES−BALL_STEP: ball_y = V_RES−BALL_SIZE, dy becomes up.
    - Otherwise: ball_y ± BALL_STEP.
  - Paddle 1 hit, when all hold:
    - dx is left;
    - ball_x ≥ PADDLE_X1+PADDLE_W;
    - ball_x−BALL_STEP < PADDLE_X1+PADDLE_W;
    - vertical overlap: ball_y+BALL_SIZE > paddle1_y and ball_y < paddle1_y+PADDLE_H.
    - Result: ball_x = PADDLE_X1+PADDLE_W, dx becomes right.
  - Paddle 2 hit: mirror image on the face at PADDLE_X2. Result: ball_x = PADDLE_X2−BALL_SIZE, dx becomes left.
  - Miss:
    - dx left and ball_x < BALL_STEP: point to player 2.
    - dx right and ball_x+BALL_SIZE > H_RES−BALL_STEP: point to player 1.
    - Either miss → POINT.
  - Otherwise: ball_x ± BALL_STEP.
  - A paddle hit overrides a miss in the same tick. The wall and paddle checks are independent, so a corner hit flips both dx and dy.
- **POINT:** lasts exactly one clock.
  - Increments the scorer's score.
  - If the new score = WIN_SCORE → OVER; else → SERVE.
  - Re-centres the ball. The next serve dx points toward the player who conceded.
- **OVER:** positions and scores frozen, game_over = 1. start_pulse clears the scores, re-centres the ball and paddles, and → SERVE.
- **Scores:** 4-bit and never exceed WIN_SCORE. All position arithmetic is 10-bit unsigned; the saturation rules above prevent underflow.

## Timing
- All outputs are registered and update on the iVGA_CLK edge after the cycle in which frame_tick is high; state/position latency is 1 clock from the tick.
- Button-to-effect latency: 2 sync clocks, then the next frame_tick. A button must be high at the synchronised sample taken in the tick cycle.
- start_pulse is a one-clock pulse, 3 clocks after the rising edge of `start`. It is acted on in IDLE and OVER and ignored in every other state.
- POINT occupies the single clock after the miss tick; frame_tick cannot recur within it.
- SERVE → PLAY on the SERVE_FRAMES-th tick. The ball first moves on the following tick.
- Asserting iRST_n low in any state forces every output to its reset value immediately, without waiting for a clock edge. Operation resumes in IDLE on the first clock edge after release.

## Test plan
- **Reset:** pulse iRST_n low mid-PLAY, asynchronously → outputs immediately read paddles 208, ball (316,236), scores 0, game_state 0.
- **Paddle saturation:** hold up1 for 60 ticks in SERVE → paddle1_y reaches 0 and stays 0. Then up1 and down1 together → holds 0. Then down1 only → saturates at 416.
- **Wall bounce:** PLAY, ball_y = 1, dy up, tick → ball_y = 0 and dy down. Next tick → ball_y = 2.
- **Paddle hit:** paddle1_y = 200, ball (25,220), dx left, tick → ball_x = 24, dx right.
- **Miss and game over:**
  - Leave paddle 2 away from the ball; the ball crosses x > 630 → POINT for 1 clock, score1 +1, then SERVE.
  - Repeat to 7 → game_state 4, game_over 1, scores frozen.
- **Restart:** start pulse in OVER → scores 0, game_state 1. After 60 ticks → game_state 2.
